// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM behind the MAR/MDR bus.
// One request is taken per rising edge of read|write while idle. It then
// runs through an optional wait phase, a single access cycle and a single
// done cycle. mem_ready and err pulse only in the done cycle.
module mem_responder #(
  parameter int ADDR_W      = 9,   // RAM index width, must be < 32
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1    // 0..15 extra cycles before the access
) (
  input  logic              clk,
  input  logic              reset,     // async, active low
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] mdatain,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  // Request snapshot taken at acceptance. The legality flags are decided here,
  // on the full 32-bit address, before the index is truncated.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              both;  // read and write together: nothing is done
    logic              oor;   // upper address bits set: no write, a read gives 0
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] wd;
  } req_t;

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              req_prev;
  req_t              req_in, req_lat;
  logic              req, accept;
  logic              access, wr_ok, rd_ok;
  logic [DATA_W-1:0] ram [2**ADDR_W];

  assign req    = read | write;
  assign accept = (state == S_IDLE) & req & ~req_prev;

  assign req_in.rd   = read;
  assign req_in.wr   = write;
  assign req_in.both = read & write;
  assign req_in.oor  = |addr[31:ADDR_W];
  assign req_in.idx  = addr[ADDR_W-1:0];
  assign req_in.wd   = wdata;

  assign access = (state == S_ACCESS);
  assign wr_ok  = access & req_lat.wr & ~req_lat.both & ~req_lat.oor;
  assign rd_ok  = access & req_lat.rd & ~req_lat.both;

  assign mem_ready = (state == S_DONE);
  assign err       = (state == S_DONE) & (req_lat.both | req_lat.oor);
  assign busy      = (state != S_IDLE);

  // State, wait counter and the strobe history used for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      req_prev <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      req_prev <= req;
    end
  end

  // Sequencing: idle -> [wait] -> access -> done -> idle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS_LOAD;
          end else begin
            state_nxt = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_ACCESS;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ACCESS: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Capture the request at acceptance. Strobes are ignored after that.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      req_lat <= '0;
    else if (accept) req_lat <= req_in;
  end

  // The RAM is not cleared by reset. A reset before the access cycle drops the write.
  always_ff @(posedge clk) begin
    if (wr_ok) ram[req_lat.idx] <= req_lat.wd;
  end

  // Read data register. It holds its value until the next completed read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     mdatain <= '0;
    else if (rd_ok) mdatain <= req_lat.oor ? '0 : ram[req_lat.idx];
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Three instances (WAIT_STATES 1, 0, 3) share one
// stimulus stream. Each instance is checked every cycle against a
// transaction-level model: it counts the edges left until the access, and it
// keeps a RAM array per instance.
module tb_mem_responder;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] mdat [N];
  logic        rdy [N], bsy [N], er [N];

  int n_chk = 0, n_pass = 0;
  int rdy_cnt [N], err_cnt [N];

  function automatic int ws_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))) u_dut (
      .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr), .wdata(wdata),
      .mdatain(mdat[g]), .mem_ready(rdy[g]), .busy(bsy[g]), .err(er[g]));
  end

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, k, a, e, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mram [N][512];
  logic        m_act [N], m_prev [N], m_ill [N];
  int          m_left [N];      // edges remaining until the access edge; 0 = in done cycle
  logic [31:0] m_mdat [N];
  logic        p_rd [N], p_wr [N];
  logic [31:0] p_addr [N], p_wd [N];
  logic        mreq, mrise;

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < N; k++) begin
      if (!reset) begin
        m_act[k] = 1'b0; m_prev[k] = 1'b0; m_mdat[k] = '0; m_left[k] = 0; m_ill[k] = 1'b0;
      end else begin
        mreq      = read | write;
        mrise     = mreq & ~m_prev[k];
        m_prev[k] = mreq;
        if (m_act[k]) begin
          if (m_left[k] == 0) m_act[k] = 1'b0;
          else begin
            m_left[k]--;
            if (m_left[k] == 0 && !(p_rd[k] && p_wr[k])) begin
              if (p_addr[k] >= 32'd512) begin
                if (p_rd[k]) m_mdat[k] = '0;
              end else if (p_wr[k]) mram[k][p_addr[k][8:0]] = p_wd[k];
              else m_mdat[k] = mram[k][p_addr[k][8:0]];
            end
          end
        end else if (mrise) begin
          m_act[k]  = 1'b1;
          m_left[k] = ws_of(k) + 1;
          p_rd[k] = read; p_wr[k] = write; p_addr[k] = addr; p_wd[k] = wdata;
          m_ill[k]  = (read && write) || (addr >= 32'd512);
        end
      end
    end
  end

  // Compare process: every cycle, every instance, all outputs.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      chk("mem_ready", k, 32'(rdy[k]), 32'(m_act[k] && m_left[k] == 0));
      chk("err",       k, 32'(er[k]),  32'(m_act[k] && m_left[k] == 0 && m_ill[k]));
      chk("busy",      k, 32'(bsy[k]), 32'(m_act[k]));
      chk("mdatain",   k, mdat[k],     m_mdat[k]);
      if (rdy[k]) rdy_cnt[k]++;
      if (er[k])  err_cnt[k]++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle();
    int t = 0;
    do begin
      @(posedge clk); #2; t++;
    end while ((bsy[0] || bsy[1] || bsy[2]) && t < 30);
    chk("idle_timeout", 0, 32'(bsy[0] || bsy[1] || bsy[2]), 32'd0);
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    read = rd; write = wr; addr = a; wdata = d;
    @(posedge clk); #2;
    read = 1'b0; write = 1'b0;
    wait_idle();
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < N; k++) begin rdy_cnt[k] = 0; err_cnt[k] = 0; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    int first [N];
    int r;
    logic [31:0] a;

    // Reset held with read asserted: everything stays quiet.
    reset = 1'b0; read = 1'b1; addr = 32'h0000_1000;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_mdatain", 0, mdat[0], 32'd0);
      chk("rst_ready",   0, 32'(rdy[0]), 32'd0);
      chk("rst_busy",    0, 32'(bsy[0]), 32'd0);
      chk("rst_err",     0, 32'(er[0]),  32'd0);
    end
    #1 reset = 1'b1;
    @(posedge clk); #2 read = 1'b0;
    wait_idle();

    // Give every address used by the random phase a known value.
    for (int i = 0; i < 32; i++) do_req(1'b0, 1'b1, 32'(i), $urandom);

    // Write then read back.
    do_req(1'b0, 1'b1, 32'd85, 32'hDEADBEEF);
    clr_cnt();
    do_req(1'b1, 1'b0, 32'd85, 32'd0);
    chk("rd85_data",  0, mdat[0], 32'hDEADBEEF);
    chk("rd85_pulse", 0, 32'(rdy_cnt[0]), 32'd1);

    // Latency, counted in edges from acceptance (inclusive) to ready.
    for (int k = 0; k < N; k++) first[k] = -1;
    @(posedge clk); #2 read = 1'b1; addr = 32'd2;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) if (first[k] < 0 && rdy[k]) first[k] = n;
      if (n == 1) begin #1 read = 1'b0; end
    end
    chk("lat_ws1", 0, 32'(first[0]), 32'd3);
    chk("lat_ws0", 1, 32'(first[1]), 32'd2);
    chk("lat_ws3", 2, 32'(first[2]), 32'd5);
    wait_idle();

    // A strobe held for 6 cycles is one request. Re-raising it makes a second one.
    clr_cnt();
    @(posedge clk); #2 read = 1'b1; addr = 32'd3;
    repeat (6) @(posedge clk);
    #2 read = 1'b0;
    wait_idle();
    for (int k = 0; k < N; k++) chk("held_once", k, 32'(rdy_cnt[k]), 32'd1);
    do_req(1'b1, 1'b0, 32'd3, 32'd0);
    for (int k = 0; k < N; k++) chk("held_rerun", k, 32'(rdy_cnt[k]), 32'd2);

    // Illegal requests.
    do_req(1'b0, 1'b1, 32'd4, 32'h1111_2222);
    clr_cnt();
    do_req(1'b1, 1'b1, 32'd4, 32'h0BAD_0BAD);
    chk("both_err",   0, 32'(err_cnt[0]), 32'd1);
    chk("both_ready", 0, 32'(rdy_cnt[0]), 32'd1);
    do_req(1'b1, 1'b0, 32'h0000_0200, 32'd0);
    chk("oor_data", 0, mdat[0], 32'd0);
    chk("oor_err",  0, 32'(err_cnt[0]), 32'd2);
    do_req(1'b1, 1'b0, 32'd4, 32'd0);
    chk("ram4_kept", 0, mdat[0], 32'h1111_2222);
    chk("ram4_noerr", 0, 32'(err_cnt[0]), 32'd2);

    // Reset during the wait phase aborts the write.
    do_req(1'b0, 1'b1, 32'd7, 32'd100);
    @(posedge clk); #2 write = 1'b1; addr = 32'd7; wdata = 32'd5;
    @(posedge clk); #2 write = 1'b0; reset = 1'b0;
    #1 chk("abort_busy", 0, 32'(bsy[0]), 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    wait_idle();
    do_req(1'b1, 1'b0, 32'd7, 32'd0);
    for (int k = 0; k < N; k++) chk("abort_old", k, mdat[k], 32'd100);

    // Random traffic, with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 99) == 0) reset = 1'b0;
      r = $urandom_range(0, 9);
      read  = (r < 3);
      write = (r >= 2 && r < 5);
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 8388607)) << 9);
      addr  = a;
      wdata = $urandom;
    end
    @(posedge clk); #2 read = 1'b0; write = 1'b0; reset = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
